// File: rtl/neuron_input_buffer.sv
// Operand staging buffer: serial shift-in or parallel feedback load, broadcast to all neurons of a layer.
// Latency: operands visible 1 cycle after accept/capture; readout registered, 1 cycle after out_rd.
// Backpressure: data_ready drops when FULL or when not in LOAD; out_rd is never stalled.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   mode               00 LOAD, 01 HOLD, 10 FEEDBACK, 11 CLEAR
//   data_in/_valid     serial operand stream, handshaked with data_ready
//   neuron_outputs     previous-layer outputs, parallel-loaded when fb_valid in FEEDBACK
//   neuron_inputs      stored operands, channel i at [i*DATA_W +: DATA_W]
//   inputs_valid       buffer is FULL
//   load_count         operands currently held, 0..NUM_CH
//   out_sel/out_rd     readout channel select and request strobe
//   network_output     registered readout value, out_valid high for one cycle per request
module neuron_input_buffer #(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 4,
   parameter int IDX_W  = 2
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [1:0]               mode,
   input  logic [DATA_W-1:0]        data_in,
   input  logic                     data_valid,
   output logic                     data_ready,
   input  logic [NUM_CH*DATA_W-1:0] neuron_outputs,
   input  logic                     fb_valid,
   output logic [NUM_CH*DATA_W-1:0] neuron_inputs,
   output logic                     inputs_valid,
   output logic [IDX_W:0]           load_count,
   input  logic [IDX_W-1:0]         out_sel,
   input  logic                     out_rd,
   output logic [DATA_W-1:0]        network_output,
   output logic                     out_valid
);

   localparam logic [1:0] MODE_LOAD  = 2'b00;
   localparam logic [1:0] MODE_HOLD  = 2'b01;
   localparam logic [1:0] MODE_FB    = 2'b10;
   localparam logic [1:0] MODE_CLEAR = 2'b11;

   localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(NUM_CH);
   localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_FULL    = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0] ch_q [NUM_CH];
   logic [DATA_W-1:0] ch_d [NUM_CH];

   // Low through reset and until the first clock edge after release, so the
   // handshake cannot complete while the buffer is still coming out of reset.
   logic              run_q;

   logic              accept;
   logic              sel_in_range;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   assign data_ready = run_q && (mode == MODE_LOAD) && (state_q != ST_FULL);
   assign accept     = data_valid && data_ready;

   // ------------------------------------------------------------------
   // Next-state / datapath
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_d[i] = ch_q[i];
      end

      case (mode)
         MODE_LOAD: begin
            // accept already excludes FULL, so a full buffer is never overwritten
            if (accept) begin
               ch_d[0] = data_in;
               for (int i = 1; i < NUM_CH; i++) begin
                  ch_d[i] = ch_q[i-1];
               end
               cnt_d   = cnt_q + CNT_ONE;
               state_d = (cnt_d == CNT_FULL) ? ST_FULL : ST_FILLING;
            end
         end

         MODE_FB: begin
            // Without fb_valid this mode is indistinguishable from HOLD
            if (fb_valid) begin
               for (int i = 0; i < NUM_CH; i++) begin
                  ch_d[i] = neuron_outputs[i*DATA_W +: DATA_W];
               end
               cnt_d   = CNT_FULL;
               state_d = ST_FULL;
            end
         end

         MODE_CLEAR: begin
            for (int i = 0; i < NUM_CH; i++) begin
               ch_d[i] = '0;
            end
            cnt_d   = '0;
            state_d = ST_EMPTY;
         end

         MODE_HOLD: begin
         end

         default: begin
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_EMPTY;
         cnt_q   <= '0;
         run_q   <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            ch_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         run_q   <= 1'b1;
         for (int i = 0; i < NUM_CH; i++) begin
            ch_q[i] <= ch_d[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // Status outputs
   // ------------------------------------------------------------------
   assign inputs_valid = (state_q == ST_FULL);
   assign load_count   = cnt_q;

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_bcast
         assign neuron_inputs[g*DATA_W +: DATA_W] = ch_q[g];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Readout port
   // ------------------------------------------------------------------
   // Only reachable when NUM_CH is not a power of two; such selects read 0.
   assign sel_in_range = ({1'b0, out_sel} < CNT_FULL);

   // Reads ch_q, i.e. the content before this edge's shift or feedback.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         network_output <= '0;
         out_valid      <= 1'b0;
      end else if (out_rd) begin
         out_valid      <= 1'b1;
         network_output <= sel_in_range ? ch_q[out_sel] : '0;
      end else begin
         out_valid      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_neuron_input_buffer.sv
module tb_neuron_input_buffer;

   localparam logic [1:0] M_LOAD  = 2'b00;
   localparam logic [1:0] M_HOLD  = 2'b01;
   localparam logic [1:0] M_FB    = 2'b10;
   localparam logic [1:0] M_CLEAR = 2'b11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn;

   // Instance A: default 4 x 8-bit
   logic [1:0]  a_mode;
   logic [7:0]  a_din;
   logic        a_dv, a_dr;
   logic [31:0] a_nout;
   logic        a_fbv;
   logic [31:0] a_nin;
   logic        a_iv;
   logic [2:0]  a_cnt;
   logic [1:0]  a_sel;
   logic        a_rd;
   logic [7:0]  a_no;
   logic        a_ov;

   // Instance B: 3 x 12-bit
   logic [1:0]  b_mode;
   logic [11:0] b_din;
   logic        b_dv, b_dr;
   logic [35:0] b_nout;
   logic        b_fbv;
   logic [35:0] b_nin;
   logic        b_iv;
   logic [2:0]  b_cnt;
   logic [1:0]  b_sel;
   logic        b_rd;
   logic [11:0] b_no;
   logic        b_ov;

   neuron_input_buffer #(.DATA_W(8), .NUM_CH(4), .IDX_W(2)) u_a (
      .clk(clk), .rstn(rstn), .mode(a_mode), .data_in(a_din), .data_valid(a_dv),
      .data_ready(a_dr), .neuron_outputs(a_nout), .fb_valid(a_fbv),
      .neuron_inputs(a_nin), .inputs_valid(a_iv), .load_count(a_cnt),
      .out_sel(a_sel), .out_rd(a_rd), .network_output(a_no), .out_valid(a_ov)
   );

   neuron_input_buffer #(.DATA_W(12), .NUM_CH(3), .IDX_W(2)) u_b (
      .clk(clk), .rstn(rstn), .mode(b_mode), .data_in(b_din), .data_valid(b_dv),
      .data_ready(b_dr), .neuron_outputs(b_nout), .fb_valid(b_fbv),
      .neuron_inputs(b_nin), .inputs_valid(b_iv), .load_count(b_cnt),
      .out_sel(b_sel), .out_rd(b_rd), .network_output(b_no), .out_valid(b_ov)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [63:0] q_a[$];
   logic [63:0] q_b[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Readout monitors: every out_valid cycle must match the oldest queued expectation.
   always @(negedge clk) begin
      if (a_ov === 1'b1) begin
         if (q_a.size() == 0) begin
            n_checks++;
            $display("FAIL a_readout: got %0h with out_valid, expected no readout", a_no);
         end else begin
            chk("a_readout", 64'(a_no), q_a.pop_front());
         end
      end
      if (b_ov === 1'b1) begin
         if (q_b.size() == 0) begin
            n_checks++;
            $display("FAIL b_readout: got %0h with out_valid, expected no readout", b_no);
         end else begin
            chk("b_readout", 64'(b_no), q_b.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [7:0] load_vals [4];
   logic [7:0] fb_exp    [4];

   initial begin
      load_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      fb_exp    = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

      rstn   = 1'b0;
      a_mode = M_LOAD; a_din = '0; a_dv = 0; a_nout = '0; a_fbv = 0; a_sel = '0; a_rd = 0;
      b_mode = M_LOAD; b_din = '0; b_dv = 0; b_nout = '0; b_fbv = 0; b_sel = '0; b_rd = 0;

      // ---------------- reset state ----------------
      step(2);
      chk("rst_data_ready",   64'(a_dr),  64'd0);
      chk("rst_load_count",   64'(a_cnt), 64'd0);
      chk("rst_inputs_valid", 64'(a_iv),  64'd0);
      chk("rst_out_valid",    64'(a_ov),  64'd0);
      chk("rst_net_output",   64'(a_no),  64'd0);
      chk("rst_neuron_in",    64'(a_nin), 64'd0);
      chk("rst_b_data_ready", 64'(b_dr),  64'd0);

      rstn = 1'b1;
      chk("rel_ready_before_edge", 64'(a_dr), 64'd0);
      step();
      chk("rel_ready_after_edge", 64'(a_dr), 64'd1);

      // ---------------- serial fill ----------------
      for (int k = 0; k < 4; k++) begin
         a_din = load_vals[k];
         a_dv  = 1'b1;
         step();
         if (k == 0) begin
            chk("fill1_count", 64'(a_cnt), 64'd1);
            chk("fill1_iv",    64'(a_iv),  64'd0);
            chk("fill1_nin",   64'(a_nin), 64'h0000_0011);
         end
      end
      chk("full_count", 64'(a_cnt), 64'd4);
      chk("full_iv",    64'(a_iv),  64'd1);
      chk("full_ready", 64'(a_dr),  64'd0);
      chk("full_nin",   64'(a_nin), 64'h1122_3344);

      // LOAD while FULL: offered sample ignored
      a_din = 8'h55;
      step();
      chk("ovf_nin",   64'(a_nin), 64'h1122_3344);
      chk("ovf_count", 64'(a_cnt), 64'd4);
      chk("ovf_ready", 64'(a_dr),  64'd0);
      a_dv = 1'b0;

      // ---------------- feedback with same-cycle readout ----------------
      a_mode = M_FB; a_fbv = 1'b1; a_nout = 32'hD3C2_B1A0;
      a_rd = 1'b1; a_sel = 2'd0; q_a.push_back(64'h44);
      step();
      a_rd = 1'b0; a_fbv = 1'b0; a_mode = M_HOLD;
      chk("fb_nin",   64'(a_nin), 64'hD3C2_B1A0);
      chk("fb_count", 64'(a_cnt), 64'd4);
      chk("fb_iv",    64'(a_iv),  64'd1);

      // FEEDBACK without fb_valid holds
      a_mode = M_FB; a_nout = 32'h0102_0304;
      step();
      chk("fbhold_nin", 64'(a_nin), 64'hD3C2_B1A0);
      a_mode = M_HOLD;

      // ---------------- back-to-back readout ----------------
      for (int s = 0; s < 4; s++) begin
         a_rd  = 1'b1;
         a_sel = 2'(s);
         q_a.push_back(64'(fb_exp[s]));
         step();
         chk("burst_ov_high", 64'(a_ov), 64'd1);
      end
      a_rd = 1'b0;
      step();
      chk("burst_ov_low",  64'(a_ov), 64'd0);
      chk("burst_no_hold", 64'(a_no), 64'hD3);

      // ---------------- clear ----------------
      a_mode = M_CLEAR;
      step();
      a_mode = M_LOAD;
      #1;
      chk("clr_nin",   64'(a_nin), 64'd0);
      chk("clr_count", 64'(a_cnt), 64'd0);
      chk("clr_ready", 64'(a_dr),  64'd1);

      a_dv = 1'b1; a_din = 8'h66; step();
      a_din = 8'h77; step();
      a_dv = 1'b0;
      chk("part_count", 64'(a_cnt), 64'd2);
      chk("part_nin",   64'(a_nin), 64'h0000_6677);
      chk("part_iv",    64'(a_iv),  64'd0);

      // CLEAR ignores data_valid and fb_valid
      a_mode = M_CLEAR; a_dv = 1'b1; a_din = 8'h99; a_fbv = 1'b1; a_nout = 32'hFFFF_FFFF;
      step();
      a_mode = M_LOAD; a_dv = 1'b0; a_fbv = 1'b0;
      #1;
      chk("clr2_nin",   64'(a_nin), 64'd0);
      chk("clr2_count", 64'(a_cnt), 64'd0);
      chk("clr2_iv",    64'(a_iv),  64'd0);
      chk("clr2_ready", 64'(a_dr),  64'd1);

      // ---------------- asynchronous reset mid-fill ----------------
      a_dv = 1'b1; a_din = 8'h12; step();
      a_din = 8'h34; step();
      a_dv = 1'b0;
      chk("pre_rst_count", 64'(a_cnt), 64'd2);
      #2 rstn = 1'b0;
      #1;
      chk("arst_no",    64'(a_no),  64'd0);
      chk("arst_nin",   64'(a_nin), 64'd0);
      chk("arst_count", 64'(a_cnt), 64'd0);
      chk("arst_ready", 64'(a_dr),  64'd0);
      chk("arst_iv",    64'(a_iv),  64'd0);
      step(2);
      rstn = 1'b1;
      step();
      chk("rerel_ready", 64'(a_dr), 64'd1);
      a_dv = 1'b1; a_din = 8'h5A;
      step();
      a_dv = 1'b0;
      chk("rerel_count", 64'(a_cnt), 64'd1);
      chk("rerel_nin",   64'(a_nin), 64'h0000_005A);

      // ---------------- NUM_CH=3, DATA_W=12 ----------------
      b_dv = 1'b1; b_din = 12'h101; step();
      b_din = 12'h202; step();
      b_din = 12'h303; step();
      b_dv = 1'b0;
      chk("b_count", 64'(b_cnt), 64'd3);
      chk("b_iv",    64'(b_iv),  64'd1);
      chk("b_ready", 64'(b_dr),  64'd0);
      chk("b_nin",   64'(b_nin), 64'h1_0120_2303);

      b_rd = 1'b1;
      b_sel = 2'd3; q_b.push_back(64'h0);   step();
      b_sel = 2'd2; q_b.push_back(64'h101); step();
      b_sel = 2'd0; q_b.push_back(64'h303); step();
      b_rd = 1'b0;
      step();
      chk("b_ov_low", 64'(b_ov), 64'd0);

      // ---------------- drain ----------------
      step(2);
      chk("a_queue_empty", 64'(q_a.size()), 64'd0);
      chk("b_queue_empty", 64'(q_b.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/neuron_input_buffer.md
Name: neuron_input_buffer

Overview:
- Parametrised input staging buffer for one layer of the neuron array.
- Holds NUM_CH operands that are broadcast to every neuron of the current layer, as "operand i to all neurons".
- Operands are filled serially from the external data stream with a valid/ready handshake, or loaded in parallel from the previous layer's neuron outputs.
- Any stored channel can be read back as the network output through a registered read port, under control of the layer-sequencing state machine.

Parameters:
- DATA_W, 8: width of one operand / neuron output in bits.
- NUM_CH, 4: number of channels (neuron inputs per layer); must be at least 2.
- IDX_W, 2: channel index width; must equal clog2(NUM_CH).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- mode  in  2  operating mode from the sequencer: 00 LOAD, 01 HOLD, 10 FEEDBACK, 11 CLEAR.
- data_in  in  DATA_W  serial operand stream.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  buffer accepts data_in this cycle.
- neuron_outputs  in  NUM_CH*DATA_W  previous layer outputs; channel i at [i*DATA_W +: DATA_W].
- fb_valid  in  1  neuron_outputs are valid for a parallel load.
- neuron_inputs  out  NUM_CH*DATA_W  stored operands; channel i at [i*DATA_W +: DATA_W].
- inputs_valid  out  1  all NUM_CH operands present (state FULL).
- load_count  out  IDX_W+1  number of operands currently held, 0..NUM_CH.
- out_sel  in  IDX_W  channel selected for readout.
- out_rd  in  1  readout request strobe.
- network_output  out  DATA_W  registered readout value.
- out_valid  out  1  network_output updated this cycle.

Behaviour:
- Reset (rstn=0, asynchronous, any time including mid-fill or mid-readout):
  - All channels 0; load_count 0; state EMPTY.
  - network_output 0; out_valid 0; inputs_valid 0; data_ready 0.
  - Outputs are released on the first clk edge with rstn=1.
- State machine: EMPTY (count 0), FILLING (0<count<NUM_CH), FULL (count=NUM_CH).
  - inputs_valid = (state==FULL), driven from a register.
- data_ready is combinational: 1 iff mode==LOAD and state!=FULL. A sample is accepted when data_valid and data_ready are both 1.
- LOAD, on accept:
  - ch0 <= data_in; ch[i] <= ch[i-1] for i=1..NUM_CH-1 (shift).
  - load_count increments.
  - Transitions: EMPTY->FILLING, or FILLING->FULL when count reaches NUM_CH. With NUM_CH=2, EMPTY->FILLING->FULL.
  - After NUM_CH accepts, ch[NUM_CH-1] holds the first sample.
- LOAD while FULL: data_ready=0; data_valid is ignored and no shift occurs (no overwrite or wrap).
- HOLD: all channels, count and state unchanged; data_ready=0.
- FEEDBACK with fb_valid=1:
  - ch[i] <= neuron_outputs channel i for all i, in one cycle.
  - load_count <= NUM_CH; state -> FULL, from any state.
- FEEDBACK with fb_valid=0: behaves as HOLD.
- CLEAR: channels zeroed, load_count 0, state EMPTY in one cycle. data_valid and fb_valid are ignored.
- Readout (independent of mode):
  - When out_rd=1 at an edge: network_output <= ch[out_sel] and out_valid <= 1 for exactly that one following cycle.
  - The value read is the pre-edge content, so a same-cycle shift or feedback is not visible.
  - out_rd=0: network_output holds and out_valid <= 0.
  - out_sel >= NUM_CH (only possible when NUM_CH is not a power of 2): network_output <= 0, out_valid <= 1.
  - Back-to-back out_rd is allowed: one result per cycle, out_valid stays high.
- Latency:
  - Serial operand appears on neuron_inputs 1 cycle after accept.
  - Feedback appears 1 cycle after capture.
  - Readout is 1 cycle after out_rd.
- Mode changes take effect at the next edge; no partial operations occur.

Test Plan:
- Reset then LOAD, data_valid=1 with 0x11,0x22,0x33,0x44 on consecutive cycles -> ch3..ch0 = 11,22,33,44; load_count 4; inputs_valid=1 on the cycle after the 4th accept; data_ready=0 thereafter.
- Full buffer, LOAD, data_valid=1 with 0x55 -> no change to any channel, count stays 4, data_ready=0.
- Full buffer, FEEDBACK with fb_valid=1, neuron_outputs={0xD3,0xC2,0xB1,0xA0} -> ch0..ch3 = A0,B1,C2,D3 next cycle; count 4; same-cycle out_rd with out_sel=0 returns the old ch0 (0x44).
- Two samples loaded (FILLING), CLEAR -> all channels 0, count 0, inputs_valid 0, data_ready 1 again in LOAD.
- out_rd held for 4 cycles with out_sel 0,1,2,3 on a full buffer -> network_output sequence equals ch0..ch3; out_valid high for 4 cycles, then low.
- rstn asserted low mid-fill after 2 accepts, between edges -> all outputs 0 immediately, without waiting for an edge; after release, the next accept gives load_count=1.
- NUM_CH=3, DATA_W=12 build: 3 accepts give FULL; out_sel=3 returns 0 with out_valid=1.
